// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment constants and scan FSM encoding
package seven_seg_pkg;

    // Active-low patterns, bit6=a .. bit0=g
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] ZERO  = 7'h01;
    localparam logic [6:0] ONE   = 7'h4F;
    localparam logic [6:0] TWO   = 7'h12;
    localparam logic [6:0] THREE = 7'h06;
    localparam logic [6:0] FOUR  = 7'h4C;
    localparam logic [6:0] FIVE  = 7'h24;
    localparam logic [6:0] SIX   = 7'h20;
    localparam logic [6:0] SEVEN = 7'h0F;
    localparam logic [6:0] EIGHT = 7'h00;
    localparam logic [6:0] NINE  = 7'h04;

    // Active-low digit enables, an[1]=left, an[0]=right
    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_LEFT  = 2'b01;
    localparam logic [1:0] AN_RIGHT = 2'b10;

    typedef enum logic [1:0] {
        DEAD_L = 2'd0,
        ON_L   = 2'd1,
        DEAD_R = 2'd2,
        ON_R   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// rtl/seven_seg_scan_mux_if.sv - pattern inputs and scanned outputs; duty only with SCAN_DIM_EN
interface seven_seg_scan_mux_if;
    logic [6:0] seg_l;
    logic [6:0] seg_r;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;
`ifdef SCAN_DIM_EN
    logic [3:0] duty;

    modport master (output seg_l, seg_r, duty, input seg, an, frame_tick);
    modport slave  (input seg_l, seg_r, duty, output seg, an, frame_tick);
`else
    modport master (output seg_l, seg_r, input seg, an, frame_tick);
    modport slave  (input seg_l, seg_r, output seg, an, frame_tick);
`endif
endinterface

// File: rtl/seven_seg_scan_timer.sv
// rtl/seven_seg_scan_timer.sv - slot counter with end-of-ghost and end-of-slot strobes
module seven_seg_scan_timer #(
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic ghost_end,
    output logic slot_end
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign ghost_end = (cnt_q == CNT_W'(GHOST_CYC - 1));
    assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));

    // Count up, wrapping at the slot end; clear holds the count at zero
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || slot_end) begin
            cnt_d = '0;
        end
    end

    // Slot counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/seven_seg_scan_mux.sv
// rtl/seven_seg_scan_mux.sv - two-digit scan multiplexer with ghost blanking; SCAN_DIM_EN adds pwm dimming
module seven_seg_scan_mux
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    seven_seg_scan_mux_if.slave   bus
);
    scan_state_e state_q, state_d;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        tick_q, tick_d;
    logic [6:0]  shadow_l_q, shadow_l_d;
    logic [6:0]  shadow_r_q, shadow_r_d;
    logic        start_q, start_d;
    logic        ghost_end;
    logic        slot_end;
    logic        load;
    logic        lit_ok;
`ifdef SCAN_DIM_EN
    logic [3:0]  pwm_q, pwm_d;
`endif

    // The first clock after reset behaves like the frame wrap edge, so the
    // timer is held at zero for it and every frame starts identically.
    seven_seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .GHOST_CYC (GHOST_CYC)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_q),
        .ghost_end (ghost_end),
        .slot_end  (slot_end)
    );

    // Next state, shadow loading and output decode from the next state
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        if (!start_q) begin
            case (state_q)
                DEAD_L:  if (ghost_end) state_d = ON_L;
                ON_L:    if (slot_end)  state_d = DEAD_R;
                DEAD_R:  if (ghost_end) state_d = ON_R;
                ON_R:    if (slot_end)  state_d = DEAD_L;
                default: state_d = DEAD_L;
            endcase
        end

        load       = start_q || (state_q == ON_R && slot_end);
        tick_d     = load;
        shadow_l_d = load ? bus.seg_l : shadow_l_q;
        shadow_r_d = load ? bus.seg_r : shadow_r_q;

`ifdef SCAN_DIM_EN
        pwm_d  = pwm_q + 4'd1;
        lit_ok = (pwm_d <= bus.duty);
`else
        lit_ok = 1'b1;
`endif

        an_d  = AN_OFF;
        seg_d = BLANK;
        if (state_d == ON_L && lit_ok) begin
            an_d  = AN_LEFT;
            seg_d = shadow_l_q;
        end else if (state_d == ON_R && lit_ok) begin
            an_d  = AN_RIGHT;
            seg_d = shadow_r_q;
        end
    end

    // State, shadows and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= DEAD_L;
            an_q       <= AN_OFF;
            seg_q      <= BLANK;
            tick_q     <= 1'b0;
            shadow_l_q <= BLANK;
            shadow_r_q <= BLANK;
            start_q    <= 1'b1;
`ifdef SCAN_DIM_EN
            pwm_q      <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            tick_q     <= tick_d;
            shadow_l_q <= shadow_l_d;
            shadow_r_q <= shadow_r_d;
            start_q    <= start_d;
`ifdef SCAN_DIM_EN
            pwm_q      <= pwm_d;
`endif
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;

    an_never_both: assert property (@(posedge clock) disable iff (reset) an_q != 2'b00);
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// tb/tb_seven_seg_scan_mux.sv - scoreboard bench for seven_seg_scan_mux; SCAN_DIM_EN adds dimming checks
module tb_seven_seg_scan_mux;
    import seven_seg_pkg::*;

    typedef struct packed {
        logic       tick;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t a_e;
    int   a_cyc = 0;

    always #5 clock = ~clock;

    seven_seg_scan_mux_if ifa ();
    seven_seg_scan_mux_if ifb ();

    seven_seg_scan_mux #(.SCAN_DIV(8), .GHOST_CYC(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    seven_seg_scan_mux #(.SCAN_DIV(4), .GHOST_CYC(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected cycles of one 16-cycle frame for SCAN_DIV=8, GHOST_CYC=2
    task automatic push_frame(input logic [6:0] l, input logic [6:0] r, input int upto);
        exp_t e;
        for (int c = 0; c < upto; c++) begin
            e.tick = (c == 0);
            if (c < 2)       begin e.an = 2'b11; e.seg = 7'h7F; end
            else if (c < 8)  begin e.an = 2'b01; e.seg = l;     end
            else if (c < 10) begin e.an = 2'b11; e.seg = 7'h7F; end
            else             begin e.an = 2'b10; e.seg = r;     end
            exp_q.push_back(e);
        end
    endtask

    // Monitor A: pops one expected cycle per clock while the scoreboard holds entries
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            a_e = exp_q.pop_front();
            check($sformatf("a_cycle%0d", a_cyc), {22'd0, ifa.frame_tick, ifa.an, ifa.seg}, {22'd0, a_e});
            a_cyc++;
        end
    end

    // Monitor B: lit cycles per digit and frame length between frame ticks
    logic b_en = 1'b0;
    bit   b_started = 1'b0;
    int   b_lit_l = 0, b_lit_r = 0, b_len = 0;
    always @(negedge clock) begin
        if (b_en) begin
            if (ifb.frame_tick) begin
                if (b_started) begin
                    check("b_lit_left", b_lit_l, 1);
                    check("b_lit_right", b_lit_r, 1);
                    check("b_frame_len", b_len, 8);
                end
                b_started = 1'b1;
                b_lit_l = 0;
                b_lit_r = 0;
                b_len = 0;
            end
            b_len++;
            if (ifb.an == 2'b01) b_lit_l++;
            if (ifb.an == 2'b10) b_lit_r++;
        end else begin
            b_started = 1'b0;
        end
    end

`ifdef SCAN_DIM_EN
    seven_seg_scan_mux_if ifc ();

    seven_seg_scan_mux #(.SCAN_DIV(32), .GHOST_CYC(1)) dut_c (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    logic [3:0] pwm_m = 4'd0;
    logic [3:0] duty_s = 4'd0;
    logic       c_en = 1'b0;
    bit         c_started = 1'b0;
    int         c_k = 0;
    logic [1:0] c_exp;

    always @(posedge clock) begin
        pwm_m  <= reset ? 4'd0 : pwm_m + 4'd1;
        duty_s <= ifc.duty;
    end

    // Monitor C: frame position from frame_tick, lit only in ON slots when pwm <= duty
    always @(negedge clock) begin
        if (c_en) begin
            if (ifc.frame_tick) begin
                c_started = 1'b1;
                c_k = 0;
            end else begin
                c_k++;
            end
            if (c_started) begin
                c_exp = 2'b11;
                if ((c_k % 32) != 0 && pwm_m <= duty_s) c_exp = (c_k < 32) ? 2'b01 : 2'b10;
                check($sformatf("c_an_duty%0d_k%0d", duty_s, c_k), {30'd0, ifc.an}, {30'd0, c_exp});
            end
        end
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        ifa.seg_l = 7'h01;
        ifa.seg_r = 7'h4F;
        ifb.seg_l = 7'h06;
        ifb.seg_r = 7'h12;
`ifdef SCAN_DIM_EN
        ifa.duty = 4'd15;
        ifb.duty = 4'd15;
        ifc.duty = 4'd15;
        ifc.seg_l = 7'h24;
        ifc.seg_r = 7'h20;
`endif
        reset = 1'b1;

        repeat (3) begin
            @(negedge clock);
            check("rst_an", {30'd0, ifa.an}, 32'h3);
            check("rst_seg", {25'd0, ifa.seg}, 32'h7F);
            check("rst_tick", {31'd0, ifa.frame_tick}, 32'h0);
        end
        reset = 1'b0;

        @(posedge clock);
        #1;
        for (int f = 0; f < 5; f++) push_frame(7'h01, 7'h4F, 16);
        push_frame(7'h12, 7'h4F, 16);
        push_frame(7'h12, 7'h4F, 13);
        a_e.tick = 1'b0;
        a_e.an = 2'b11;
        a_e.seg = 7'h7F;
        exp_q.push_back(a_e);
        push_frame(7'h24, 7'h30, 16);
        b_en = 1'b1;

        repeat (69) @(posedge clock);
        #1;
        ifa.seg_l = 7'h12;

        repeat (39) @(posedge clock);
        #1;
        reset = 1'b1;
        b_en = 1'b0;
        ifa.seg_l = 7'h24;
        ifa.seg_r = 7'h30;

        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clock);
        #1;
        check("a_queue_drained", exp_q.size(), 0);

`ifdef SCAN_DIM_EN
        c_en = 1'b1;
        ifc.duty = 4'd15;
        repeat (128) @(posedge clock);
        #1;
        ifc.duty = 4'd3;
        repeat (64) @(posedge clock);
        #1;
        ifc.duty = 4'd0;
        repeat (64) @(posedge clock);
        #1;
        c_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
